// File: rtl/op_pipe_pkg.sv
// Shared constants and types for the operand-pair pipeline.
package op_pipe_pkg;

  // Operation codes selected by the MODE parameter of op_pipe_stream.
  localparam int OP_XOR = 0;
  localparam int OP_ADD = 1;
  localparam int OP_SUB = 2;
  localparam int OP_AND = 3;

  // Default operand width and the matching operand-pair layout {a, b}.
  localparam int OP_PAIR_WIDTH = 32;

  typedef struct packed {
    logic [OP_PAIR_WIDTH-1:0] a;
    logic [OP_PAIR_WIDTH-1:0] b;
  } op_pair_t;

  // Bits needed to carry one operand pair of the given operand width.
  function automatic int pair_bits(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/op_pipe_stage.sv
// One valid/ready register slice. Advances when empty or when the slice
// downstream advances; data only loads when a valid item actually enters.
module op_pipe_stage
  import op_pipe_pkg::*;
#(
  parameter int WIDTH = pair_bits(OP_PAIR_WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             down_advance_i,
  output logic             advance_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Advance condition and next state; flush wins over any incoming item.
  always_comb begin
    advance_o = !valid_q || down_advance_i;
    valid_d   = valid_q;
    data_d    = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (advance_o) begin
      valid_d = up_valid_i;
    end
    if (advance_o && up_valid_i && !flush_i) begin
      data_d = up_data_i;
    end
  end

  // Slice registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/op_pipe_stream.sv
// Streaming operand-pair pipeline: DEPTH delay slices carrying {a, b},
// then a result register holding op(a, b) and its carry/borrow.
module op_pipe_stream
  import op_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int MODE  = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [WIDTH-1:0]            in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_carry,
  output logic [$clog2(DEPTH+2)-1:0]  occupancy
);

  localparam int PW    = pair_bits(WIDTH);
  localparam int OCC_W = $clog2(DEPTH + 2);

  // Element gi feeds slice gi; element DEPTH feeds the result register.
  logic [DEPTH:0]  chain_valid;
  logic [DEPTH:0]  chain_adv;
  logic [PW-1:0]   chain_data [DEPTH+1];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_carry_q, out_carry_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [WIDTH-1:0] a_last, b_last;
  logic [WIDTH:0]   res_full;
  logic             in_xfer, out_xfer;

  assign chain_valid[0] = in_valid;
  assign chain_data[0]  = {in_a, in_b};

  genvar gi;
  generate
    if (WIDTH < 1 || DEPTH < 1 || DEPTH > 16) begin : g_bad_size
      $error("op_pipe_stream: WIDTH must be >= 1 and DEPTH in 1..16");
    end

    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      op_pipe_stage #(.WIDTH(PW)) u_stage (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush_i        (flush),
        .up_valid_i     (chain_valid[gi]),
        .up_data_i      (chain_data[gi]),
        .down_advance_i (chain_adv[gi+1]),
        .advance_o      (chain_adv[gi]),
        .valid_o        (chain_valid[gi+1]),
        .data_o         (chain_data[gi+1])
      );
    end

    // The operation is fixed at elaboration; one (WIDTH+1)-bit form covers
    // all modes so bit WIDTH is the carry/borrow or a constant zero.
    if (MODE == OP_XOR) begin : g_xor
      assign res_full = {1'b0, a_last ^ b_last};
    end else if (MODE == OP_ADD) begin : g_add
      assign res_full = {1'b0, a_last} + {1'b0, b_last};
    end else if (MODE == OP_SUB) begin : g_sub
      assign res_full = {1'b0, a_last} - {1'b0, b_last};
    end else if (MODE == OP_AND) begin : g_and
      assign res_full = {1'b0, a_last & b_last};
    end else begin : g_bad_mode
      $error("op_pipe_stream: MODE must be 0 (XOR), 1 (ADD), 2 (SUB) or 3 (AND)");
      assign res_full = '0;
    end
  endgenerate

  assign a_last = chain_data[DEPTH][PW-1:WIDTH];
  assign b_last = chain_data[DEPTH][WIDTH-1:0];

  // Ready chain terminates at the result register; inputs are refused while flushing.
  always_comb begin
    chain_adv[DEPTH] = !out_valid_q || out_ready;
    in_ready         = chain_adv[0] && !flush;
    in_xfer          = in_valid && in_ready;
    out_xfer         = out_valid_q && out_ready;
  end

  // Result register next state and occupancy bookkeeping.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_carry_d = out_carry_q;
    occ_d       = occ_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (chain_adv[DEPTH]) begin
      out_valid_d = chain_valid[DEPTH];
    end
    if (chain_adv[DEPTH] && chain_valid[DEPTH] && !flush) begin
      out_data_d  = res_full[WIDTH-1:0];
      out_carry_d = res_full[WIDTH];
    end
    if (flush) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Result and occupancy registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_carry_q <= out_carry_d;
      occ_q       <= occ_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_op_pipe_stream.sv
// Directed and random bench for op_pipe_stream (8-bit, depth 2). The ADD
// instance is scoreboarded; SUB and XOR instances check single results.
module tb_op_pipe_stream;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_carry;
  logic [1:0] occupancy;

  logic       s_valid, s_ready, s_out_valid, s_carry;
  logic [7:0] s_data;
  logic [1:0] s_occ;
  logic       x_valid, x_ready, x_out_valid, x_carry;
  logic [7:0] x_data;
  logic [1:0] x_occ;
  logic       side_flush;
  logic       side_out_ready;
  logic [7:0] s_a, s_b, x_a, x_b;

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int nbase;
  logic [8:0] sb[$];
  logic       stall_prev = 1'b0;
  logic [8:0] held;

  op_pipe_stream #(.WIDTH(8), .DEPTH(2), .MODE(1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .occupancy(occupancy)
  );

  op_pipe_stream #(.WIDTH(8), .DEPTH(2), .MODE(2)) dut_sub (
    .clk(clk), .reset_n(reset_n), .flush(side_flush),
    .in_valid(s_valid), .in_ready(s_ready), .in_a(s_a), .in_b(s_b),
    .out_valid(s_out_valid), .out_ready(side_out_ready), .out_data(s_data),
    .out_carry(s_carry), .occupancy(s_occ)
  );

  op_pipe_stream #(.WIDTH(8), .DEPTH(2), .MODE(0)) dut_xor (
    .clk(clk), .reset_n(reset_n), .flush(side_flush),
    .in_valid(x_valid), .in_ready(x_ready), .in_a(x_a), .in_b(x_b),
    .out_valid(x_out_valid), .out_ready(side_out_ready), .out_data(x_data),
    .out_carry(x_carry), .occupancy(x_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: called just after a negedge with inputs set; records
  // handshakes against the scoreboard and moves to the next negedge.
  task automatic tick();
    logic [8:0] exp;
    #1;
    check("occupancy", 32'(occupancy), 32'(sb.size()));
    if (stall_prev && out_valid) check("stall_stable", 32'({out_carry, out_data}), 32'(held));
    if (in_valid && in_ready) begin
      sb.push_back({1'b0, in_a} + {1'b0, in_b});
      n_in++;
    end
    if (out_valid && out_ready) begin
      check("output_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("result", 32'({out_carry, out_data}), 32'(exp));
      end
    end
    stall_prev = out_valid && !out_ready;
    held       = {out_carry, out_data};
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    side_flush = 1'b0; side_out_ready = 1'b1;
    s_valid = 1'b0; x_valid = 1'b0;
    s_a = 8'h02; s_b = 8'h05; x_a = 8'hA5; x_b = 8'h0F;

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Back-to-back ADD pairs, latency DEPTH+1, plus single SUB/XOR results
    in_valid = 1'b1; in_a = 8'h05; in_b = 8'h03; s_valid = 1'b1; x_valid = 1'b1;
    tick();
    check("lat_c1_valid", 32'(out_valid), 32'd0);
    in_a = 8'hFF; in_b = 8'h02; s_valid = 1'b0; x_valid = 1'b0;
    tick();
    check("lat_c2_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    check("c3_valid", 32'(out_valid), 32'd1);
    check("c3_data", 32'(out_data), 32'h08);
    check("c3_carry", 32'(out_carry), 32'd0);
    check("sub_valid", 32'(s_out_valid), 32'd1);
    check("sub_data", 32'(s_data), 32'hFD);
    check("sub_borrow", 32'(s_carry), 32'd1);
    check("xor_valid", 32'(x_out_valid), 32'd1);
    check("xor_data", 32'(x_data), 32'hAA);
    check("xor_carry", 32'(x_carry), 32'd0);
    tick();
    check("c4_valid", 32'(out_valid), 32'd1);
    check("c4_data", 32'(out_data), 32'h01);
    check("c4_carry", 32'(out_carry), 32'd1);
    tick();
    check("c5_valid", 32'(out_valid), 32'd0);

    // Backpressure: 5 offered with out_ready low, only DEPTH+1 accepted
    out_ready = 1'b0;
    nbase = n_in;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 8'(8'h10 * i + 1); in_b = 8'(8'h30 + i);
      tick();
    end
    check("bp_accepted", 32'(n_in - nbase), 32'd3);
    check("bp_occupancy", 32'(occupancy), 32'd3);
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    check("bp_drained", 32'(sb.size()), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd0);

    // Random valid/ready traffic, 1000 pairs
    nbase = n_in;
    for (int c = 0; c < 20000 && (n_in - nbase) < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("rand_count", 32'(n_in - nbase), 32'd1000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    check("rand_drained", 32'(sb.size()), 32'd0);

    // Flush with two in flight and a pair offered in the flush cycle
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = 8'h11; in_b = 8'h22; tick();
    in_a = 8'h33; in_b = 8'h44; tick();
    check("fl_occ_before", 32'(occupancy), 32'd2);
    flush = 1'b1; in_a = 8'h55; in_b = 8'h66;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete(); stall_prev = 1'b0;
    check("fl_occupancy", 32'(occupancy), 32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (4) tick();

    // Flush coinciding with an output handshake
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 8'(8'h70 + i); in_b = 8'(8'h90 + i);
      tick();
    end
    in_valid = 1'b0;
    check("fl2_occ_full", 32'(occupancy), 32'd3);
    check("fl2_out_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete(); stall_prev = 1'b0;
    check("fl2_occupancy", 32'(occupancy), 32'd0);
    check("fl2_out_valid_after", 32'(out_valid), 32'd0);
    repeat (4) tick();

    // Asynchronous reset mid-stream
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom);
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_occupancy", 32'(occupancy), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_carry", 32'(out_carry), 32'd0);
    sb.delete(); stall_prev = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid_rel", 32'(out_valid), 32'd0);
    @(negedge clk);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
